// File: rtl/instruc_assembler_pkg.sv
// Shared constants and state encoding for the UART instruction loader.
// The splitter on the transmit side uses the same word and byte constants.
package instruc_assembler_pkg;

  localparam int N_BYTES_DEF = 4;
  localparam int DATA_W_DEF  = 8;
  localparam int WORD_W_DEF  = N_BYTES_DEF * DATA_W_DEF;

  localparam logic [WORD_W_DEF-1:0] HALT_WORD_DEF = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    IDLE,
    RECV,
    WRITE,
    DONE
  } state_t;

endpackage

// File: rtl/inter_byte_timer.sv
// Counts idle cycles between bytes of one word.
// expired_o is raised once TIMEOUT-1 idle cycles have been seen.
module inter_byte_timer #(
  parameter int TIMEOUT = 50000
) (
  input  logic clk,
  input  logic reset,
  input  logic clear_i,
  input  logic enable_i,
  output logic expired_o
);

  localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

  logic [CW-1:0] count_q, count_d;

  assign expired_o = (count_q == LAST);

  // The counter saturates at LAST so expired_o stays up until cleared.
  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (enable_i && !expired_o) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/instruc_assembler.sv
// Packs UART bytes into instruction words and writes them to instruction
// memory at consecutive addresses until HALT, a full address space, or disable.
module instruc_assembler
  import instruc_assembler_pkg::*;
#(
  parameter int N_BYTES = N_BYTES_DEF,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int ADDR_W  = 8,
  parameter int TIMEOUT = 50000,
  parameter logic [N_BYTES*DATA_W-1:0] HALT_WORD = HALT_WORD_DEF
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      recibir,
  input  logic                      rx_done_tick,
  input  logic [DATA_W-1:0]         rx_data,
  output logic [N_BYTES*DATA_W-1:0] salida,
  output logic                      wr,
  output logic [ADDR_W-1:0]         addr,
  output logic                      done,
  output logic                      full,
  output logic                      timeout_err
);

  localparam int WORD_W = N_BYTES * DATA_W;
  localparam int CNT_W  = $clog2(N_BYTES + 1);

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [WORD_W-1:0]   buf_q, buf_d;
  logic [WORD_W-1:0]   salida_q, salida_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                done_q, done_d;
  logic                full_q, full_d;
  logic                terr_q, terr_d;

  logic [CNT_W-1:0]    sel;
  logic [WORD_W-1:0]   word_w;
  logic                last_w;
  logic                capture;
  logic                expired;

  inter_byte_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk       (clk),
    .reset     (reset),
    .clear_i   (rx_done_tick || (state_q != RECV)),
    .enable_i  (state_q == RECV),
    .expired_o (expired)
  );

  // A byte outside RECV always starts a new word, so it lands in slot 0.
  always_comb begin
    sel    = (state_q == RECV) ? cnt_q : '0;
    word_w = buf_q;
    word_w[int'(sel)*DATA_W +: DATA_W] = rx_data;
    last_w = (sel == CNT_W'(N_BYTES - 1));
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    buf_d    = buf_q;
    salida_d = salida_q;
    addr_d   = addr_q;
    done_d   = done_q;
    full_d   = full_q;
    terr_d   = 1'b0;
    capture  = 1'b0;

    case (state_q)
      IDLE: begin
        if (recibir && rx_done_tick) capture = 1'b1;
      end
      RECV: begin
        if (!recibir) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (rx_done_tick) begin
          capture = 1'b1;
        end else if (expired) begin
          state_d = IDLE;
          cnt_d   = '0;
          terr_d  = 1'b1;
        end
      end
      WRITE: begin
        if ((salida_q == HALT_WORD) || (addr_q == '1)) begin
          if (recibir) begin
            state_d = DONE;
            done_d  = 1'b1;
            full_d  = (salida_q != HALT_WORD);
          end else begin
            state_d = IDLE;
            addr_d  = '0;
          end
        end else begin
          addr_d  = addr_q + 1'b1;
          state_d = IDLE;
          if (recibir && rx_done_tick) capture = 1'b1;
        end
      end
      DONE: begin
        if (!recibir) begin
          state_d = IDLE;
          done_d  = 1'b0;
          full_d  = 1'b0;
          addr_d  = '0;
        end
      end
      default: state_d = IDLE;
    endcase

    if (capture) begin
      buf_d = word_w;
      if (last_w) begin
        salida_d = word_w;
        cnt_d    = '0;
        state_d  = WRITE;
      end else begin
        cnt_d   = sel + 1'b1;
        state_d = RECV;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      buf_q    <= '0;
      salida_q <= '0;
      addr_q   <= '0;
      done_q   <= 1'b0;
      full_q   <= 1'b0;
      terr_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      buf_q    <= buf_d;
      salida_q <= salida_d;
      addr_q   <= addr_d;
      done_q   <= done_d;
      full_q   <= full_d;
      terr_q   <= terr_d;
    end
  end

  assign salida      = salida_q;
  assign wr          = (state_q == WRITE);
  assign addr        = addr_q;
  assign done        = done_q;
  assign full        = full_q;
  assign timeout_err = terr_q;

endmodule

// File: tb/tb_instruc_assembler.sv
// Self-checking bench: directed loader scenarios plus random byte streams,
// compared against a queue-based model of the expected memory writes.
module tb_instruc_assembler;

  localparam int ADDR_W  = 2;
  localparam int TIMEOUT = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic        recibir;
  logic        rx_done_tick;
  logic [7:0]  rx_data;
  logic [31:0] salida;
  logic        wr;
  logic [1:0]  addr;
  logic        done;
  logic        full;
  logic        timeout_err;

  always #5 clk = ~clk;

  instruc_assembler #(
    .ADDR_W  (ADDR_W),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .recibir      (recibir),
    .rx_done_tick (rx_done_tick),
    .rx_data      (rx_data),
    .salida       (salida),
    .wr           (wr),
    .addr         (addr),
    .done         (done),
    .full         (full),
    .timeout_err  (timeout_err)
  );

  int compared   = 0;
  int mismatched = 0;

  logic [33:0] wrLog[$];
  logic [33:0] expQ[$];
  int          terrSeen = 0;
  int          expTerr  = 0;

  logic [7:0]  partial[$];
  int          mAddr    = 0;
  int          idleRun  = 0;
  bit          mDone    = 1'b0;
  bit          mFull    = 1'b0;

  // Record every write and timeout pulse seen on the DUT outputs.
  always @(negedge clk) begin
    if (wr) wrLog.push_back({addr, salida});
    if (timeout_err) terrSeen++;
  end

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: collect bytes, emit one write per completed group of four.
  task automatic modelByte(input logic [7:0] b);
    logic [31:0] word;
    if (!recibir || mDone) return;
    partial.push_back(b);
    idleRun = 0;
    if (partial.size() == 4) begin
      word = {partial[3], partial[2], partial[1], partial[0]};
      expQ.push_back({2'(mAddr), word});
      partial.delete();
      if (word == 32'hFFFF_FFFF) begin
        mDone = 1'b1;
      end else if (mAddr == (1 << ADDR_W) - 1) begin
        mDone = 1'b1;
        mFull = 1'b1;
      end else begin
        mAddr++;
      end
    end
  endtask

  task automatic idleCycles(input int n);
    repeat (n) begin
      @(negedge clk);
      idleRun++;
      if (partial.size() > 0 && idleRun == TIMEOUT) begin
        partial.delete();
        expTerr++;
      end
    end
  endtask

  task automatic applyStimulus(input logic [7:0] b, input int gap);
    rx_data      = b;
    rx_done_tick = 1'b1;
    modelByte(b);
    @(negedge clk);
    rx_done_tick = 1'b0;
    idleCycles(gap);
  endtask

  task automatic sendWord(input logic [31:0] w, input int gap);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(w[8*i +: 8], gap);
    end
  endtask

  task automatic setRecibir(input bit v);
    recibir = v;
    if (!v) begin
      partial.delete();
      if (mDone) begin
        mDone = 1'b0;
        mFull = 1'b0;
        mAddr = 0;
      end
    end
    @(negedge clk);
  endtask

  task automatic checkpoint(input string tag);
    int n;
    idleCycles(3);
    #1;
    checkOutput({tag, ".writes"}, wrLog.size(), expQ.size());
    n = (wrLog.size() < expQ.size()) ? wrLog.size() : expQ.size();
    for (int i = 0; i < n; i++) begin
      checkOutput($sformatf("%s.wr%0d", tag, i), wrLog[i], expQ[i]);
    end
    checkOutput({tag, ".done"}, done, mDone);
    checkOutput({tag, ".full"}, full, mFull);
    checkOutput({tag, ".terr"}, terrSeen, expTerr);
    wrLog.delete();
    expQ.delete();
  endtask

  task automatic doReset();
    #2;
    reset        = 1'b1;
    rx_done_tick = 1'b0;
    #1;
    checkOutput("rst.salida", salida, 32'h0);
    checkOutput("rst.wr", wr, 1'b0);
    checkOutput("rst.addr", addr, 2'd0);
    checkOutput("rst.done", done, 1'b0);
    checkOutput("rst.full", full, 1'b0);
    checkOutput("rst.terr", timeout_err, 1'b0);
    partial.delete();
    mAddr   = 0;
    mDone   = 1'b0;
    mFull   = 1'b0;
    idleRun = 0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    int pulses;
    int firstPulse;
    logic [7:0] b;
    int gap;

    reset        = 1'b1;
    recibir      = 1'b0;
    rx_done_tick = 1'b0;
    rx_data      = 8'h00;
    repeat (2) @(negedge clk);
    #1;
    checkOutput("init.salida", salida, 32'h0);
    checkOutput("init.wr", wr, 1'b0);
    checkOutput("init.addr", addr, 2'd0);
    checkOutput("init.done", done, 1'b0);
    checkOutput("init.full", full, 1'b0);
    checkOutput("init.terr", timeout_err, 1'b0);
    @(negedge clk);
    reset = 1'b0;

    // Bytes while disabled must be ignored.
    applyStimulus(8'h55, 2);
    setRecibir(1'b1);

    // Normal word with wide gaps.
    sendWord(32'hFF00_FF00, 10);
    checkpoint("normal");

    // Two words then HALT; later bytes are ignored.
    sendWord(32'h4433_2211, 1);
    sendWord(32'h2001_008C, 1);
    sendWord(32'hFFFF_FFFF, 1);
    sendWord(32'h7856_3412, 1);
    checkpoint("halt");
    setRecibir(1'b0);
    checkpoint("halt_release");
    setRecibir(1'b1);

    // Timeout after two bytes: pulse on the 16th idle edge.
    applyStimulus(8'h5A, 0);
    applyStimulus(8'hA5, 0);
    pulses     = 0;
    firstPulse = 0;
    for (int k = 1; k <= 20; k++) begin
      idleCycles(1);
      if (timeout_err) begin
        pulses++;
        if (firstPulse == 0) firstPulse = k;
      end
    end
    checkOutput("timeout.pulses", pulses, 1);
    checkOutput("timeout.cycle", firstPulse, TIMEOUT);
    sendWord(32'h0403_0201, 1);
    checkpoint("timeout");

    // Back-to-back: next word's first byte arrives during the write cycle.
    sendWord(32'h4030_2010, 0);
    sendWord(32'hDDCC_BBAA, 0);
    checkpoint("b2b");

    // Fill the address space from a fresh session.
    setRecibir(1'b0);
    setRecibir(1'b1);
    for (int w = 0; w < 5; w++) begin
      sendWord({$urandom_range(0, 255), 8'h01} | 32'h0, 0);
    end
    checkpoint("full");
    setRecibir(1'b0);
    setRecibir(1'b1);

    // Random stream with gaps straddling the timeout and occasional disables.
    for (int i = 0; i < 300; i++) begin
      b   = ($urandom_range(0, 1) == 1) ? 8'hFF : 8'($urandom_range(0, 255));
      gap = ($urandom_range(0, 9) == 0) ? $urandom_range(TIMEOUT - 2, TIMEOUT + 1)
                                        : $urandom_range(0, 2);
      applyStimulus(b, gap);
      if ($urandom_range(0, 39) == 0 || (mDone && $urandom_range(0, 3) == 0)) begin
        setRecibir(1'b0);
        idleCycles($urandom_range(0, 3));
        setRecibir(1'b1);
      end
      if (i % 25 == 24) checkpoint($sformatf("rand%0d", i));
    end
    checkpoint("rand_end");

    // Asynchronous reset mid-word, then a silent abort by disabling.
    setRecibir(1'b0);
    setRecibir(1'b1);
    applyStimulus(8'h01, 0);
    applyStimulus(8'h02, 0);
    applyStimulus(8'h03, 0);
    doReset();
    checkpoint("reset_mid");
    applyStimulus(8'h11, 0);
    applyStimulus(8'h22, 0);
    setRecibir(1'b0);
    idleCycles(20);
    checkpoint("abort");
    setRecibir(1'b1);
    sendWord(32'h0D0C_0B0A, 1);
    checkpoint("after_abort");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/instruc_assembler.md
Name: instruc_assembler

Overview:
- Receive-side counterpart of the instruction splitter. It collects 8-bit bytes delivered by the UART receiver and packs each group of N_BYTES into one 32-bit instruction word.
- Each completed word is issued as a single-cycle write, with an auto-incrementing address, towards instruction memory.
- Loading ends on a HALT word, on a full address space, or when the enable is withdrawn.
- A partially received word is discarded after an inactivity timeout.

Parameters:
- N_BYTES, 4, bytes per word. Byte 0 is received first and lands in bits [7:0].
- DATA_W, 8, UART byte width.
- ADDR_W, 8, instruction-memory address width.
- TIMEOUT, 50000, maximum idle clock cycles allowed between bytes of one word.
- HALT_WORD, 32'hFFFF_FFFF, word that terminates loading.

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- recibir  in  1  load enable; a session runs while this is high.
- rx_done_tick  in  1  one-cycle strobe from the UART receiver meaning a byte is valid.
- rx_data  in  DATA_W  received byte; sampled only when rx_done_tick=1.
- salida  out  N_BYTES*DATA_W  assembled word; stable while wr=1.
- wr  out  1  one-cycle memory write strobe.
- addr  out  ADDR_W  write address for the current salida.
- done  out  1  level; loading finished.
- full  out  1  level; address space exhausted.
- timeout_err  out  1  one-cycle pulse; a partial word was discarded.

Behaviour:
- Reset: all outputs go to 0. The byte counter is 0, the internal address is 0, the timeout counter is 0, and the state is IDLE.
- States: IDLE, RECV, WRITE, DONE.
- IDLE
  - If recibir=0: nothing is accepted and rx_done_tick is ignored.
  - If recibir=1 and rx_done_tick=1: store rx_data in byte slot 0, set byte count to 1, and go to RECV.
- RECV
  - Each rx_done_tick stores rx_data in slot[count] and increments count.
  - When the final byte (count = N_BYTES-1) is stored, go to WRITE on the same edge.
- WRITE (exactly one cycle)
  - wr=1, salida holds the packed word, addr holds the current address.
  - Latency: wr is high in the cycle immediately after the edge that captured the last byte.
  - Exit on the next edge:
    - If salida == HALT_WORD: go to DONE with done=1. The HALT word itself is written.
    - Else if addr == 2^ADDR_W-1: go to DONE with done=1 and full=1.
    - Else: increment the address and go to IDLE.
  - An rx_done_tick arriving during WRITE on the continuing path is captured as byte 0 of the next word and the next state is RECV. On a path into DONE it is dropped.
- Timeout
  - In RECV the counter increments every cycle without rx_done_tick and clears when a byte arrives.
  - When it reaches TIMEOUT-1: discard the partial word, clear the byte count, pulse timeout_err for one cycle, and go to IDLE.
  - The address is not advanced.
- recibir falling
  - In RECV: the partial word is discarded silently (no timeout_err) and the state goes to IDLE.
  - In WRITE: the write still completes, then the state goes to IDLE.
  - In DONE: done and full clear, the address resets to 0, and the state goes to IDLE.
- Session start: the internal address resets to 0 whenever IDLE is entered from DONE, or on reset.
- DONE: held while recibir=1. All rx_done_tick strobes are ignored and no wr is produced.
- Asynchronous reset mid-word: the partial word is lost and no wr is issued.
- salida is registered and holds its last value outside WRITE. Consumers use it only when wr=1.

Decomposition:
- Shared package holds the state encoding (IDLE/RECV/WRITE/DONE) and the HALT_WORD default constant. The splitter reuses the same word/byte constants.
- Sub-module: inter_byte_timer. This is the timeout counter, with inputs clear and enable and output expired.
- The rest stays in one FSM module.

Test Plan:
1. Normal word: recibir=1; send bytes 0x00,0xFF,0x00,0xFF, 20 cycles apart -> one wr pulse with salida=32'hFF00FF00 and addr=0; done=0.
2. Two words then halt: send 0x11,0x22,0x33,0x44 -> salida=32'h44332211 at addr 0; send 0x8C,0x00,0x01,0x20 -> 32'h20_01_00_8C at addr 1; send four 0xFF -> wr with 32'hFFFFFFFF at addr 2, then done=1; further bytes produce no wr.
3. Timeout: with TIMEOUT=16, send 2 bytes then idle 20 cycles -> timeout_err pulses once at the 16th idle cycle and no wr. The next 4 bytes 0x01,0x02,0x03,0x04 -> salida=32'h04030201 at addr 0.
4. Full: with ADDR_W=2, send 4 non-halt words -> wr at addr 0,1,2,3; after the fourth, done=1 and full=1; a fifth word produces no wr.
5. Back-to-back: rx_done_tick asserted during the WRITE cycle with 0xAA -> that byte becomes bits [7:0] of the next word; the previous word is written intact.
6. Reset/enable abort: assert reset after 3 bytes -> all outputs 0 immediately, no wr. Separately, drop recibir after 2 bytes -> no wr and no timeout_err; the next session's first word goes to addr 0.
